// File: rtl/dmem_boot_loader.sv
// dmem_boot_loader: owns the dmem port after reset. It copies WORDS words from a
// combinational init ROM into dmem, reads them all back and compares, then
// releases the core's reset and passes the core's dmem port through unchanged.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   reload               re-run load/verify (only acted on while running)
//   cpu_MemWrite/cpu_DataAdr/cpu_WriteData   core data-memory request
//   rom_addr / rom_data  init ROM word index / combinational ROM word
//   MemWrite/DataAdr/WriteData               dmem write port
//   ReadData             combinational dmem read data
//   cpu_reset            reset to the core (held until verify passes)
//   done                 load and verify passed, core running
//   error / err_addr     verify mismatch flag and byte address of the mismatch
module dmem_boot_loader #(
    parameter int unsigned WORDS     = 64,
    parameter int unsigned ROM_AW    = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reload,
    input  logic              cpu_MemWrite,
    input  logic [31:0]       cpu_DataAdr,
    input  logic [31:0]       cpu_WriteData,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic              MemWrite,
    output logic [31:0]       DataAdr,
    output logic [31:0]       WriteData,
    input  logic [31:0]       ReadData,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [31:0]       err_addr
);

    localparam int unsigned IW = ROM_AW + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {LOAD, VERIFY, RUN, FAIL} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [31:0]   cur_addr;

    // Byte address of the word currently being loaded or checked (wraps mod 2^32).
    assign cur_addr = BASE_ADDR + (32'(idx) << 2);
    assign rom_addr = idx[ROM_AW-1:0];

    // Sequencer: state, word index and sticky mismatch record.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= LOAD;
            idx      <= '0;
            error    <= 1'b0;
            err_addr <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (idx == LAST_IDX) begin
                        state <= VERIFY;
                        idx   <= '0;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                VERIFY: begin
                    if (ReadData != rom_data) begin
                        state    <= FAIL;
                        error    <= 1'b1;
                        err_addr <= cur_addr;
                    end else if (idx == LAST_IDX) begin
                        state <= RUN;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                RUN: begin
                    if (reload) begin
                        state <= LOAD;
                        idx   <= '0;
                        error <= 1'b0;
                    end
                end
                FAIL: begin
                    state <= FAIL;
                end
                default: begin
                    state <= LOAD;
                    idx   <= '0;
                end
            endcase
        end
    end

    // dmem port steering; the core only reaches dmem while running.
    always_comb begin
        MemWrite  = 1'b0;
        DataAdr   = cur_addr;
        WriteData = '0;
        case (state)
            LOAD: begin
                MemWrite  = 1'b1;
                WriteData = rom_data;
            end
            VERIFY: begin
                MemWrite = 1'b0;
            end
            RUN: begin
                MemWrite  = cpu_MemWrite;
                DataAdr   = cpu_DataAdr;
                WriteData = cpu_WriteData;
            end
            FAIL: begin
                DataAdr = err_addr;
            end
            default: begin
                MemWrite = 1'b0;
            end
        endcase
        if (reset) begin
            MemWrite = 1'b0;
        end
    end

    assign cpu_reset = reset | (state != RUN);
    assign done      = (state == RUN) & ~reset;

endmodule

// File: tb/tb_dmem_boot_loader.sv
module tb_dmem_boot_loader;

    localparam int unsigned W = 4;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main instance (WORDS=4) ----------------
    logic        reset, reload;
    logic        cpu_MemWrite;
    logic [31:0] cpu_DataAdr, cpu_WriteData;
    logic [5:0]  rom_addr;
    logic [31:0] rom_data;
    logic        MemWrite;
    logic [31:0] DataAdr, WriteData, ReadData;
    logic        cpu_reset, done, error;
    logic [31:0] err_addr;

    dmem_boot_loader #(.WORDS(W), .ROM_AW(6), .BASE_ADDR(BASE)) u_dut (
        .clk(clk), .reset(reset), .reload(reload),
        .cpu_MemWrite(cpu_MemWrite), .cpu_DataAdr(cpu_DataAdr), .cpu_WriteData(cpu_WriteData),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData), .ReadData(ReadData),
        .cpu_reset(cpu_reset), .done(done), .error(error), .err_addr(err_addr)
    );

    // ---------------- boundary instance (WORDS=1, top of address space) ----------------
    logic        reset1;
    logic        cpu_MemWrite1 = 1'b0;
    logic [31:0] cpu_DataAdr1 = 32'h0, cpu_WriteData1 = 32'h0;
    logic        reload1 = 1'b0;
    logic [1:0]  rom_addr1;
    logic [31:0] rom_data1;
    logic        MemWrite1;
    logic [31:0] DataAdr1, WriteData1, ReadData1;
    logic        cpu_reset1, done1, error1;
    logic [31:0] err_addr1;
    logic [31:0] mem1 = 32'h0;
    int          n_wr1 = 0;

    dmem_boot_loader #(.WORDS(1), .ROM_AW(2), .BASE_ADDR(32'hFFFF_FFFC)) u_dut1 (
        .clk(clk), .reset(reset1), .reload(reload1),
        .cpu_MemWrite(cpu_MemWrite1), .cpu_DataAdr(cpu_DataAdr1), .cpu_WriteData(cpu_WriteData1),
        .rom_addr(rom_addr1), .rom_data(rom_data1),
        .MemWrite(MemWrite1), .DataAdr(DataAdr1), .WriteData(WriteData1), .ReadData(ReadData1),
        .cpu_reset(cpu_reset1), .done(done1), .error(error1), .err_addr(err_addr1)
    );

    assign rom_data1 = (rom_addr1 == 2'd0) ? 32'hCAFE_F00D : 32'h0;
    assign ReadData1 = mem1;
    always @(posedge clk) begin
        if (MemWrite1 && DataAdr1 == 32'hFFFF_FFFC) begin
            mem1  <= WriteData1;
            n_wr1 <= n_wr1 + 1;
        end
    end

    // ---------------- ROM and dmem models ----------------
    logic [31:0] rom [64];
    logic [31:0] dmem [32];
    logic        corrupt_en;
    logic [31:0] wq [$];
    bit          early40 = 1'b0;

    assign rom_data = rom[rom_addr];
    assign ReadData = (corrupt_en && !MemWrite && DataAdr == 32'h8) ? 32'hDEAD_BEEE
                                                                    : dmem[DataAdr[6:2]];

    always @(posedge clk) begin
        if (MemWrite) begin
            dmem[DataAdr[6:2]] <= WriteData;
            if (cpu_reset) wq.push_back(DataAdr);
            if (cpu_reset && DataAdr == 32'h40) early40 <= 1'b1;
        end
    end

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] addr_of(input int k);
        return BASE + (32'(k) << 2);
    endfunction

    // Behavioural model: boot progress counted as edges since the boot began.
    int          bc = 0;
    bit          failed = 1'b0;
    bit          mv = 1'b0;
    logic [31:0] fail_addr = 32'h0;

    always @(posedge clk) begin
        if (reset) begin
            bc     = 0;
            failed = 1'b0;
            mv     = 1'b1;
        end else if (mv && !failed) begin
            if (bc < int'(W)) begin
                bc++;
            end else if (bc < 2 * int'(W)) begin
                if (corrupt_en && addr_of(bc - int'(W)) == 32'h8) begin
                    failed    = 1'b1;
                    fail_addr = addr_of(bc - int'(W));
                end else begin
                    bc++;
                end
            end else if (reload) begin
                bc = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("m_rst_memwrite", 32'(MemWrite), 32'd0);
            chk("m_rst_cpu_reset", 32'(cpu_reset), 32'd1);
            chk("m_rst_done", 32'(done), 32'd0);
        end else if (mv) begin
            if (failed) begin
                chk("m_fail_memwrite", 32'(MemWrite), 32'd0);
                chk("m_fail_adr", DataAdr, fail_addr);
                chk("m_fail_cpu_reset", 32'(cpu_reset), 32'd1);
                chk("m_fail_done", 32'(done), 32'd0);
                chk("m_fail_error", 32'(error), 32'd1);
                chk("m_fail_err_addr", err_addr, fail_addr);
            end else if (bc < int'(W)) begin
                chk("m_load_memwrite", 32'(MemWrite), 32'd1);
                chk("m_load_adr", DataAdr, addr_of(bc));
                chk("m_load_wdata", WriteData, rom[bc]);
                chk("m_load_cpu_reset", 32'(cpu_reset), 32'd1);
                chk("m_load_done", 32'(done), 32'd0);
                chk("m_load_error", 32'(error), 32'd0);
            end else if (bc < 2 * int'(W)) begin
                chk("m_ver_memwrite", 32'(MemWrite), 32'd0);
                chk("m_ver_adr", DataAdr, addr_of(bc - int'(W)));
                chk("m_ver_wdata", WriteData, 32'd0);
                chk("m_ver_cpu_reset", 32'(cpu_reset), 32'd1);
                chk("m_ver_done", 32'(done), 32'd0);
                chk("m_ver_error", 32'(error), 32'd0);
            end else begin
                chk("m_run_memwrite", 32'(MemWrite), 32'(cpu_MemWrite));
                chk("m_run_adr", DataAdr, cpu_DataAdr);
                chk("m_run_wdata", WriteData, cpu_WriteData);
                chk("m_run_cpu_reset", 32'(cpu_reset), 32'd0);
                chk("m_run_done", 32'(done), 32'd1);
                chk("m_run_error", 32'(error), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'h0;
        for (int i = 0; i < 32; i++) dmem[i] = 32'h0;
        rom[0] = 32'h1111_1111;
        rom[1] = 32'h2222_2222;
        rom[2] = 32'hDEAD_BEEF;
        rom[3] = 32'h0000_0000;
        reset = 1'b1; reload = 1'b0; corrupt_en = 1'b0; reset1 = 1'b1;
        cpu_MemWrite = 1'b1; cpu_DataAdr = 32'h40; cpu_WriteData = 32'hAAAA_5555;
        repeat (3) step();

        // Reset state
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        chk("rst_memwrite", 32'(MemWrite), 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);

        // Normal boot with core store held on 0x40
        wq.delete();
        reset = 1'b0;
        #1;
        chk("boot_first_adr", DataAdr, 32'h0);
        chk("boot_first_we", 32'(MemWrite), 32'd1);
        repeat (7) step();
        chk("boot_done_edge7", 32'(done), 32'd0);
        step();
        chk("boot_done_edge8", 32'(done), 32'd1);
        chk("boot_cpu_reset_edge8", 32'(cpu_reset), 32'd0);
        chk("boot_error", 32'(error), 32'd0);
        chk("boot_nwrites", 32'(wq.size()), 32'd4);
        if (wq.size() == 4) begin
            chk("boot_wq0", wq[0], 32'h0);
            chk("boot_wq1", wq[1], 32'h4);
            chk("boot_wq2", wq[2], 32'h8);
            chk("boot_wq3", wq[3], 32'hC);
        end
        chk("dmem0", dmem[0], 32'h1111_1111);
        chk("dmem1", dmem[1], 32'h2222_2222);
        chk("dmem2", dmem[2], 32'hDEAD_BEEF);
        chk("dmem3", dmem[3], 32'h0000_0000);
        chk("iso_no_early_40", 32'(early40), 32'd0);
        chk("iso_40_before", dmem[16], 32'h0);
        step();
        chk("iso_40_after", dmem[16], 32'hAAAA_5555);

        // Reload in RUN with a simultaneous core store
        cpu_DataAdr = 32'h0; cpu_WriteData = 32'h5; reload = 1'b1;
        step();
        reload = 1'b0; cpu_MemWrite = 1'b0;
        chk("reload_store_done", dmem[0], 32'h5);
        chk("reload_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("reload_done_low", 32'(done), 32'd0);
        repeat (7) step();
        chk("reload_done_edge7", 32'(done), 32'd0);
        step();
        chk("reload_done_edge8", 32'(done), 32'd1);
        chk("reload_dmem0", dmem[0], 32'h1111_1111);

        // Reset mid-LOAD at idx=2
        reload = 1'b1;
        step();
        reload = 1'b0;
        step(); step();
        chk("midload_adr_idx2", DataAdr, 32'h8);
        reset = 1'b1;
        #1;
        chk("midload_rst_we", 32'(MemWrite), 32'd0);
        step();
        reset = 1'b0;
        #1;
        chk("midload_restart_adr", DataAdr, BASE);
        chk("midload_restart_we", 32'(MemWrite), 32'd1);
        repeat (7) step();
        chk("midload_done_edge7", 32'(done), 32'd0);
        step();
        chk("midload_done_edge8", 32'(done), 32'd1);

        // Verify fault on the word at 0x8
        corrupt_en = 1'b1; reload = 1'b1;
        step();
        reload = 1'b0;
        repeat (7) step();
        chk("fault_error", 32'(error), 32'd1);
        chk("fault_err_addr", err_addr, 32'h8);
        chk("fault_done", 32'(done), 32'd0);
        chk("fault_cpu_reset", 32'(cpu_reset), 32'd1);
        for (int i = 0; i < 20; i++) begin
            reload = (i % 3 == 0);
            step();
        end
        reload = 1'b0;
        chk("fault_hold_error", 32'(error), 32'd1);
        chk("fault_hold_done", 32'(done), 32'd0);
        chk("fault_hold_err_addr", err_addr, 32'h8);

        // Recovery by reset only
        corrupt_en = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("recover_error", 32'(error), 32'd0);
        chk("recover_err_addr", err_addr, 32'h0);
        repeat (8) step();
        chk("recover_done", 32'(done), 32'd1);

        // WORDS=1 at the top of the address space
        chk("w1_rst_we", 32'(MemWrite1), 32'd0);
        chk("w1_rst_cpu_reset", 32'(cpu_reset1), 32'd1);
        reset1 = 1'b0;
        #1;
        chk("w1_load_we", 32'(MemWrite1), 32'd1);
        chk("w1_load_adr", DataAdr1, 32'hFFFF_FFFC);
        chk("w1_load_wdata", WriteData1, 32'hCAFE_F00D);
        chk("w1_load_done", 32'(done1), 32'd0);
        step();
        chk("w1_ver_we", 32'(MemWrite1), 32'd0);
        chk("w1_ver_adr", DataAdr1, 32'hFFFF_FFFC);
        chk("w1_ver_done", 32'(done1), 32'd0);
        chk("w1_ver_cpu_reset", 32'(cpu_reset1), 32'd1);
        step();
        chk("w1_done", 32'(done1), 32'd1);
        chk("w1_cpu_reset", 32'(cpu_reset1), 32'd0);
        chk("w1_error", 32'(error1), 32'd0);
        chk("w1_mem", mem1, 32'hCAFE_F00D);
        chk("w1_nwrites", 32'(n_wr1), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
